// File: rtl/mv_mult_sequencer.sv
// Sequential 4x4 matrix-vector multiplier: one multiply-accumulate per cycle,
// with each row result offered to the consumer through a valid/ready handshake.
module mv_mult_sequencer #(
  parameter int unsigned COEF_W = 4,
  parameter int unsigned ELEM_W = 2,
  parameter int unsigned ACC_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [COEF_W-1:0]   cfg_data,
  input  logic                start,
  input  logic [4*ELEM_W-1:0] vector,
  output logic                busy,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [1:0]          row_idx,
  output logic [ACC_W-1:0]    row_data,
  output logic                done
);

  localparam int unsigned ProdW = COEF_W + ELEM_W;

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e                state_q, state_d;
  logic [COEF_W-1:0]     coef_q [16];
  logic [4*ELEM_W-1:0]   vec_q, vec_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [1:0]            row_q, row_d;
  logic [1:0]            col_q, col_d;
  logic                  done_q, done_d;

  logic [COEF_W-1:0]     coef_sel;
  logic [ELEM_W-1:0]     elem_sel;
  logic [ProdW-1:0]      prod;

  // The single multiplier: current coefficient times current vector element.
  always_comb begin
    coef_sel = coef_q[{row_q, col_q}];
    elem_sel = vec_q[col_q*ELEM_W +: ELEM_W];
    prod     = ProdW'(coef_sel) * ProdW'(elem_sel);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d   = vector;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_q + ACC_W'(prod);
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = StOut;
      end
      StOut: begin
        if (row_ready) begin
          if (row_q == 2'd3) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + 2'd1;
            col_d   = '0;
            acc_d   = '0;
            state_d = StCalc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      // Coefficients are frozen while a product is in flight.
      if (cfg_we && state_q == StIdle) coef_q[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    row_valid = (state_q == StOut);
    row_data  = row_valid ? acc_q : '0;
    row_idx   = row_valid ? row_q : '0;
    done      = done_q;
  end

endmodule

// File: tb/tb_mv_mult_sequencer.sv
// Randomized bench for mv_mult_sequencer: expected rows come from a plain
// dot-product model over a mirrored coefficient array.
module tb_mv_mult_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [3:0] cfg_data = '0;
  logic       start = 1'b0;
  logic [7:0] vector = '0;
  logic       busy, row_valid, done;
  logic       row_ready = 1'b1;
  logic [1:0] row_idx;
  logic [7:0] row_data;

  int n_tests = 0;
  int n_fail  = 0;
  int coef_m [16];

  mv_mult_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .vector    (vector),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) coef_m[i] = 0;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 4'(d);
    tick();
    cfg_we   = 1'b0;
    coef_m[a] = d;
  endtask

  // One full product. Optional write alongside start, optional mid-run
  // disturbance (start + cfg write while busy), optional stall on one row.
  task automatic run(input logic [7:0] v, input bit wen, input int wa, input int wd,
                     input bit disturb, input int stall_row, input int stall_n);
    int t, expt, n, sum;
    int exp_row [4];
    if (wen) coef_m[wa] = wd;
    for (int r = 0; r < 4; r++) begin
      sum = 0;
      for (int c = 0; c < 4; c++) sum += coef_m[r*4+c] * ((int'(v) >> (2*c)) & 3);
      exp_row[r] = sum % 256;
    end
    row_ready = 1'b1;
    vector    = v;
    start     = 1'b1;
    cfg_we    = wen;
    cfg_addr  = 4'(wa);
    cfg_data  = 4'(wd);
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    t      = 0;
    check("busy_after_start", 32'(busy), 1);
    check("done_one_cycle", 32'(done), 0);
    if (disturb) begin
      vector   = ~v;
      start    = 1'b1;
      cfg_we   = 1'b1;
      cfg_addr = 4'd0;
      cfg_data = 4'd9;
      tick();
      t++;
      start  = 1'b0;
      cfg_we = 1'b0;
    end
    expt = 0;
    for (int r = 0; r < 4; r++) begin
      expt += 4;
      n = 0;
      while (!row_valid && n < 40) begin
        tick();
        t++;
        n++;
      end
      check("row_valid_time", 32'(t), 32'(expt));
      check("row_data", 32'(row_data), 32'(exp_row[r]));
      check("row_idx", 32'(row_idx), 32'(r));
      if (r == stall_row) begin
        row_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          t++;
          expt++;
          check("stall_valid", 32'(row_valid), 1);
          check("stall_data", 32'(row_data), 32'(exp_row[r]));
          check("stall_idx", 32'(row_idx), 32'(r));
        end
        row_ready = 1'b1;
      end
      tick();
      t++;
      expt++;
    end
    check("done_time", 32'(done) * 32'(t), 32'(expt));
    check("busy_at_done", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] v;
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(row_valid), 0);
    check("rst_idx", 32'(row_idx), 0);
    check("rst_data", 32'(row_data), 0);
    check("rst_done", 32'(done), 0);

    // Identity diagonal with elements 0,1,2,3.
    wr(0, 1); wr(5, 1); wr(10, 1); wr(15, 1);
    run(8'hE4, 1'b0, 0, 0, 1'b0, -1, 0);

    // Saturated inputs: every row is 4*15*3.
    for (int i = 0; i < 16; i++) wr(i, 15);
    run(8'hFF, 1'b0, 0, 0, 1'b0, -1, 0);
    check("max_row_sum", 32'(coef_m[0] * 3 * 4), 180);

    // Stall on row 1 for three cycles.
    run(8'hFF, 1'b0, 0, 0, 1'b0, 1, 3);

    // Start and write while busy are ignored; a back-to-back run in the done
    // cycle then proves coef[0] kept its value.
    for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(1, 15)));
    run(8'h5B, 1'b0, 0, 0, 1'b1, -1, 0);
    run(8'h5B, 1'b0, 0, 0, 1'b0, -1, 0);

    // Write committed in the same cycle as start.
    run(8'hC3, 1'b1, 6, 7, 1'b0, -1, 0);

    // Randomized runs with random stalls, some starting in the done cycle.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1)
        for (int j = 0; j < 4; j++) wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      v = 8'($urandom);
      run(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    // Reset during row 2 CALC, then a run must produce all-zero rows.
    vector = 8'hFF;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (12) tick();
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) coef_m[i] = 0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(row_valid), 0);
    check("midrst_data", 32'(row_data), 0);
    check("midrst_done", 32'(done), 0);
    tick();
    check("midrst_no_done", 32'(done), 0);
    run(8'hFF, 1'b0, 0, 0, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
